// File: rtl/riscv_dmem_pkg.sv
// Shared encodings for the data-memory path: access size codes and controller FSM states.
package riscv_dmem_pkg;

    // Bit 2 of the size field is the unsigned-load flag; only write-back uses it.
    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HWORD = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/riscv_dmem_lane.sv
// Lane steering for one access: alignment check, byte enables and replicated store data.
module riscv_dmem_lane
    import riscv_dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        size_i,
    input  logic [2:0]        offset_i,
    input  logic [XLEN-1:0]   data_i,
    output logic              misaligned_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   data_o
);

    localparam int BW   = XLEN / 8;
    localparam int OFFW = $clog2(BW);

    logic [BW-1:0] mask;

    always_comb begin
        misaligned_o = 1'b0;
        mask         = '0;
        data_o       = data_i;
        case ({1'b0, size_i})
            SIZE_BYTE: begin
                mask   = BW'(1);
                data_o = {BW{data_i[7:0]}};
            end
            SIZE_HWORD: begin
                misaligned_o = offset_i[0];
                mask         = BW'(3);
                data_o       = {(XLEN/16){data_i[15:0]}};
            end
            SIZE_WORD: begin
                misaligned_o = |offset_i[1:0];
                mask         = BW'(4'hF);
                data_o       = {(XLEN/32){data_i[31:0]}};
            end
            default: begin
                // A doubleword never fits a 32-bit bus.
                misaligned_o = (XLEN == 32) || (|offset_i);
                mask         = '1;
                data_o       = data_i;
            end
        endcase
        be_o = mask << offset_i[OFFW-1:0];
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Single-outstanding data-memory controller between write-back and the data bus.
// Optional region check is compiled in with `define DMEM_PMA_EN.
module riscv_dmem_ctrl
    import riscv_dmem_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              TIMEOUT  = 255,
    parameter logic [XLEN-1:0] PMA_BASE = '0,
    parameter logic [XLEN-1:0] PMA_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic [XLEN-1:0]   mem_adr,
    input  logic [2:0]        mem_size,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_d,
    output logic              dmem_ack,
    output logic [XLEN-1:0]   dmem_q,
    output logic              dmem_misaligned,
    output logic              dmem_page_fault,
    output logic              bus_req,
    output logic [XLEN-1:0]   bus_adr,
    output logic              bus_we,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_d,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_q,
    input  logic              bus_err,
    output state_e            dbg_state
);

    localparam int         OFFW   = $clog2(XLEN / 8);
    localparam logic [7:0] TO_LIM = TIMEOUT[7:0];

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   adr_q, adr_d;
    logic              we_q, we_d;
    logic [XLEN/8-1:0] be_q, be_d;
    logic [XLEN-1:0]   bd_q, bd_d;
    logic [XLEN-1:0]   rq_q, rq_d;
    logic              mis_q, mis_d;
    logic              pf_q, pf_d;

    logic              lane_mis;
    logic [XLEN/8-1:0] lane_be;
    logic [XLEN-1:0]   lane_d;
    logic              size_unused;

    assign size_unused = mem_size[2];

    riscv_dmem_lane #(.XLEN(XLEN)) u_lane (
        .size_i       (mem_size[1:0]),
        .offset_i     (mem_adr[2:0]),
        .data_i       (mem_d),
        .misaligned_o (lane_mis),
        .be_o         (lane_be),
        .data_o       (lane_d)
    );

`ifdef DMEM_PMA_EN
    logic pma_miss;
    assign pma_miss = (mem_adr & PMA_MASK) != PMA_BASE;
`else
    logic pma_miss;
    logic pma_unused;
    assign pma_miss   = 1'b0;
    assign pma_unused = ^{PMA_BASE, PMA_MASK};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        adr_d   = adr_q;
        we_d    = we_q;
        be_d    = be_q;
        bd_d    = bd_q;
        rq_d    = rq_q;
        mis_d   = mis_q;
        pf_d    = pf_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    if (lane_mis) begin
                        mis_d   = 1'b1;
                        pf_d    = 1'b0;
                        rq_d    = '0;
                        state_d = DONE;
                    end else if (pma_miss) begin
                        mis_d   = 1'b0;
                        pf_d    = 1'b1;
                        rq_d    = '0;
                        state_d = DONE;
                    end else begin
                        adr_d   = {mem_adr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        we_d    = mem_we;
                        be_d    = lane_be;
                        bd_d    = lane_d;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // An ack arriving on the timeout cycle still completes normally.
                if (bus_ack) begin
                    req_d   = 1'b0;
                    rq_d    = we_q ? '0 : bus_q;
                    pf_d    = bus_err;
                    mis_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_d == TO_LIM) begin
                    req_d   = 1'b0;
                    rq_d    = '0;
                    pf_d    = 1'b1;
                    mis_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            bd_q    <= '0;
            rq_q    <= '0;
            mis_q   <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            bd_q    <= bd_d;
            rq_q    <= rq_d;
            mis_q   <= mis_d;
            pf_q    <= pf_d;
        end
    end

    assign dmem_ack        = (state_q == DONE);
    assign dmem_q          = rq_q;
    assign dmem_misaligned = mis_q;
    assign dmem_page_fault = pf_q;
    assign bus_req         = req_q;
    assign bus_adr         = adr_q;
    assign bus_we          = we_q;
    assign bus_be          = be_q;
    assign bus_d           = bd_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl (XLEN=32, TIMEOUT=4); region test built with DMEM_PMA_EN.
module tb_riscv_dmem_ctrl;
    import riscv_dmem_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic [W-1:0]  mem_adr;
    logic [2:0]    mem_size;
    logic          mem_we;
    logic [W-1:0]  mem_d;
    logic          dmem_ack;
    logic [W-1:0]  dmem_q;
    logic          dmem_misaligned;
    logic          dmem_page_fault;
    logic          bus_req;
    logic [W-1:0]  bus_adr;
    logic          bus_we;
    logic [W/8-1:0] bus_be;
    logic [W-1:0]  bus_d;
    logic          bus_ack;
    logic [W-1:0]  bus_q;
    logic          bus_err;
    state_e        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    int exp_acks = 0;
    logic [W-1:0] exp_q[$];

    riscv_dmem_ctrl #(
        .XLEN(W), .TIMEOUT(4), .PMA_BASE(32'h0), .PMA_MASK(32'hF000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_adr(mem_adr), .mem_size(mem_size), .mem_we(mem_we), .mem_d(mem_d),
        .dmem_ack(dmem_ack), .dmem_q(dmem_q), .dmem_misaligned(dmem_misaligned),
        .dmem_page_fault(dmem_page_fault),
        .bus_req(bus_req), .bus_adr(bus_adr), .bus_we(bus_we), .bus_be(bus_be), .bus_d(bus_d),
        .bus_ack(bus_ack), .bus_q(bus_q), .bus_err(bus_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (dmem_ack) ack_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic [W-1:0] adr, input logic [2:0] size,
                         input logic we, input logic [W-1:0] d);
        mem_req  = 1'b1;
        mem_adr  = adr;
        mem_size = size;
        mem_we   = we;
        mem_d    = d;
    endtask

    task automatic drop_req();
        mem_req = 1'b0;
        mem_adr = '0;
        mem_we  = 1'b0;
        mem_d   = '0;
    endtask

    // Called in BUSY cycle 1; ack lands in BUSY cycle waits+1.
    task automatic bus_resp(input string tag, input int waits, input logic [W-1:0] q, input logic err);
        for (int i = 0; i < waits; i++) begin
            check({tag, "_wait_req"}, 64'(bus_req), 64'd1);
            tick();
        end
        bus_ack = 1'b1;
        bus_q   = q;
        bus_err = err;
        tick();
        bus_ack = 1'b0;
        bus_q   = '0;
        bus_err = 1'b0;
    endtask

    // scoreboard: response flags checked here, data popped from exp_q
    task automatic expect_ack(input string tag, input logic mis, input logic pf);
        logic [W-1:0] e;
        exp_acks++;
        check({tag, "_ack"}, 64'(dmem_ack), 64'd1);
        check({tag, "_mis"}, 64'(dmem_misaligned), 64'(mis));
        check({tag, "_pf"}, 64'(dmem_page_fault), 64'(pf));
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_q"}, 64'(dmem_q), 64'(e));
        end
    endtask

    logic [W-1:0]  st_adr [3] = '{32'h203, 32'h102, 32'h300};
    logic [2:0]    st_sz  [3] = '{3'd0, 3'd1, 3'd2};
    logic [W-1:0]  st_d   [3] = '{32'h5A, 32'h1234, 32'hCAFE_F00D};
    logic [W-1:0]  st_badr[3] = '{32'h200, 32'h100, 32'h300};
    logic [3:0]    st_be  [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [W-1:0]  st_bd  [3] = '{32'h5A5A_5A5A, 32'h1234_1234, 32'hCAFE_F00D};

    logic [W-1:0]  mis_adr[3] = '{32'h101, 32'h102, 32'h100};
    logic [2:0]    mis_sz [3] = '{3'd1, 3'd2, 3'd3};

    initial begin
        rst = 1'b1;
        mem_req = 1'b0; mem_adr = '0; mem_size = '0; mem_we = 1'b0; mem_d = '0;
        bus_ack = 1'b0; bus_q = '0; bus_err = 1'b0;
        tick();
        tick();
        check("rst_ack", 64'(dmem_ack), 64'd0);
        check("rst_q", 64'(dmem_q), 64'd0);
        check("rst_mis", 64'(dmem_misaligned), 64'd0);
        check("rst_pf", 64'(dmem_page_fault), 64'd0);
        check("rst_req", 64'(bus_req), 64'd0);
        check("rst_adr", 64'(bus_adr), 64'd0);
        check("rst_we", 64'(bus_we), 64'd0);
        check("rst_be", 64'(bus_be), 64'd0);
        check("rst_d", 64'(bus_d), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        tick();

        // aligned word load, two wait cycles
        issue(32'h104, 3'd2, 1'b0, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        check("ld_req", 64'(bus_req), 64'd1);
        check("ld_adr", 64'(bus_adr), 64'h104);
        check("ld_be", 64'(bus_be), 64'hF);
        check("ld_we", 64'(bus_we), 64'd0);
        check("ld_state", 64'(dbg_state), 64'(BUSY));
        bus_resp("ld", 2, 32'hDEAD_BEEF, 1'b0);
        expect_ack("ld", 1'b0, 1'b0);
        check("ld_req_drop", 64'(bus_req), 64'd0);
        drop_req();
        tick();
        check("ld_ack_once", 64'(dmem_ack), 64'd0);
        check("ld_q_hold", 64'(dmem_q), 64'hDEAD_BEEF);
        check("ld_idle", 64'(dbg_state), 64'(IDLE));

        // stores: byte, half, word
        for (int i = 0; i < 3; i++) begin
            issue(st_adr[i], st_sz[i], 1'b1, st_d[i]);
            exp_q.push_back(32'h0);
            tick();
            check("st_req", 64'(bus_req), 64'd1);
            check("st_adr", 64'(bus_adr), 64'(st_badr[i]));
            check("st_be", 64'(bus_be), 64'(st_be[i]));
            check("st_d", 64'(bus_d), 64'(st_bd[i]));
            check("st_we", 64'(bus_we), 64'd1);
            bus_resp("st", 0, 32'hFFFF_FFFF, 1'b0);
            expect_ack("st", 1'b0, 1'b0);
            drop_req();
            tick();
        end

        // misaligned: half@101, word@102, dword on a 32-bit bus
        for (int i = 0; i < 3; i++) begin
            issue(mis_adr[i], mis_sz[i], 1'b0, 32'h0);
            exp_q.push_back(32'h0);
            tick();
            check("mis_noreq", 64'(bus_req), 64'd0);
            expect_ack("mis", 1'b1, 1'b0);
            drop_req();
            tick();
            check("mis_noreq2", 64'(bus_req), 64'd0);
            check("mis_ack_once", 64'(dmem_ack), 64'd0);
        end

        // timeout with no bus_ack: bus_req high 4 cycles
        issue(32'h400, 3'd2, 1'b0, 32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_req_high", 64'(bus_req), 64'd1);
            check("to_no_ack", 64'(dmem_ack), 64'd0);
        end
        tick();
        check("to_req_low", 64'(bus_req), 64'd0);
        expect_ack("to", 1'b0, 1'b1);
        drop_req();
        tick();

        // bus_ack on the timeout cycle wins
        issue(32'h408, 3'd2, 1'b0, 32'h0);
        exp_q.push_back(32'h1357_9BDF);
        tick();
        bus_resp("to4", 3, 32'h1357_9BDF, 1'b0);
        expect_ack("to4", 1'b0, 1'b0);
        drop_req();
        tick();

        // bus error, then a request held through DONE
        issue(32'h500, 3'd2, 1'b0, 32'h0);
        exp_q.push_back(32'h1111_2222);
        tick();
        bus_resp("err", 0, 32'h1111_2222, 1'b1);
        expect_ack("err", 1'b0, 1'b1);
        issue(32'h504, 3'd2, 1'b0, 32'h0);
        exp_q.push_back(32'h3333_4444);
        tick();
        check("b2b_idle", 64'(dbg_state), 64'(IDLE));
        check("b2b_noreq", 64'(bus_req), 64'd0);
        tick();
        check("b2b_req", 64'(bus_req), 64'd1);
        check("b2b_adr", 64'(bus_adr), 64'h504);
        bus_resp("b2b", 0, 32'h3333_4444, 1'b0);
        expect_ack("b2b", 1'b0, 1'b0);
        drop_req();
        tick();

        // reset while BUSY
        issue(32'h600, 3'd2, 1'b0, 32'h0);
        tick();
        check("rb_req", 64'(bus_req), 64'd1);
        drop_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rb_req_low", 64'(bus_req), 64'd0);
        check("rb_idle", 64'(dbg_state), 64'(IDLE));
        check("rb_adr", 64'(bus_adr), 64'd0);
        bus_ack = 1'b1;
        bus_q   = 32'hAAAA_5555;
        tick();
        bus_ack = 1'b0;
        bus_q   = '0;
        check("rb_no_ack1", 64'(dmem_ack), 64'd0);
        tick();
        check("rb_no_ack2", 64'(dmem_ack), 64'd0);
        check("rb_idle2", 64'(dbg_state), 64'(IDLE));

`ifdef DMEM_PMA_EN
        // outside the region: fault without a bus cycle
        issue(32'h8000_0000, 3'd2, 1'b0, 32'h0);
        exp_q.push_back(32'h0);
        tick();
        check("pma_noreq", 64'(bus_req), 64'd0);
        expect_ack("pma", 1'b0, 1'b1);
        drop_req();
        tick();
        // misalignment outranks the region fault
        issue(32'h8000_0001, 3'd1, 1'b0, 32'h0);
        exp_q.push_back(32'h0);
        tick();
        check("pma_mis_noreq", 64'(bus_req), 64'd0);
        expect_ack("pma_mis", 1'b1, 1'b0);
        drop_req();
        tick();
`endif

        tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("ack_total", 64'(ack_cnt), 64'(exp_acks));

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
